// File: rtl/lockin_seq_pkg.sv
// Shared types and helpers for the lock-in sample sequencer.
package lockin_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

    // ceil(log2(points)), never below 1 so a single-point index still has a bit.
    function automatic int unsigned idx_width(input int unsigned points);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if (points > (32'd1 << i)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sample_sequencer_rise_detect.sv
// Registers a same-domain level and emits a registered one-cycle pulse on its rising edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_d_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_d_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sig_d_q <= sig_i;
            rise_q  <= sig_i & ~sig_d_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sample_sequencer.sv
// Turns sinc rising edges into indexed valid/ready sample requests over a
// run of n_ciclos periods of POINTS ticks each (0 = continuous until stop).
module sample_sequencer
    import lockin_seq_pkg::*;
#(
    parameter int unsigned POINTS = 8,
    parameter int unsigned IDX_W  = idx_width(POINTS),
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sinc,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] n_ciclos,
    input  logic             sample_ready,
    output logic             sample_valid,
    output logic [IDX_W-1:0] sample_index,
    output logic             sample_first,
    output logic             sample_last,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(POINTS - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             overrun_q, overrun_d;

    logic tick;
    logic slot_free;
    logic wrap;
    logic end_run;

    rise_detect u_rise (
        .clk   (clk),
        .reset (reset),
        .sig_i (sinc),
        .rise_o(tick)
    );

    assign slot_free = ~valid_q | sample_ready;
    assign wrap      = (idx_q == IDX_LAST);
    assign end_run   = (n_q != '0) && wrap && (per_cnt_q == n_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            per_cnt_q <= '0;
            n_q       <= '0;
            valid_q   <= 1'b0;
            index_q   <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            per_cnt_q <= per_cnt_d;
            n_q       <= n_d;
            valid_q   <= valid_d;
            index_q   <= index_d;
            first_q   <= first_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        per_cnt_d = per_cnt_q;
        n_d       = n_q;
        valid_d   = valid_q;
        index_d   = index_q;
        first_d   = first_q;
        last_d    = last_q;
        overrun_d = overrun_q;

        // Accepted handshake frees the slot; a same-cycle tick below reloads it.
        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    n_d       = n_ciclos;
                    idx_d     = '0;
                    per_cnt_d = '0;
                    overrun_d = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (tick) begin
                    if (slot_free) begin
                        valid_d = 1'b1;
                        index_d = idx_q;
                        first_d = (idx_q == '0);
                        last_d  = end_run;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    if (wrap) begin
                        idx_d = '0;
                        if (!(&per_cnt_q)) begin
                            per_cnt_d = per_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (end_run) begin
                        state_d = slot_free ? DRAIN : DONE;
                    end
                end
            end
            DRAIN: begin
                if (stop) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (valid_q && sample_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sample_valid = valid_q;
    assign sample_index = index_q;
    assign sample_first = first_q;
    assign sample_last  = last_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer: POINTS=4 instance for most runs, POINTS=1 instance for the single-point case.
module tb_sample_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sinc;
    logic        start4, start1;
    logic        stop;
    logic        ready;
    logic [31:0] n_ciclos;

    logic        v4, f4, l4, b4, d4, o4;
    logic [1:0]  i4;
    logic        v1, f1, l1, b1, d1, o1;
    logic [0:0]  i1;

    logic sinc_en  = 1'b0;
    logic sinc_man = 1'b0;
    logic gen_sinc = 1'b0;
    assign sinc = sinc_en ? gen_sinc : sinc_man;

    int n_cmp = 0;
    int n_mis = 0;

    logic        mon_clr = 1'b0;
    int          cyc = 0;
    int          acc4 = 0, done_cnt4 = 0, last_acc4 = 0, done_cyc4 = 0;
    logic [31:0] idx_pack4 = '0, first_mask4 = '0, last_mask4 = '0;
    int          acc1 = 0, done_cnt1 = 0;
    logic [31:0] first_mask1 = '0, last_mask1 = '0;
    logic        idx_or1 = 1'b0;

    sample_sequencer #(.POINTS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .sinc        (sinc),
        .start       (start4),
        .stop        (stop),
        .n_ciclos    (n_ciclos),
        .sample_ready(ready),
        .sample_valid(v4),
        .sample_index(i4),
        .sample_first(f4),
        .sample_last (l4),
        .busy        (b4),
        .done        (d4),
        .overrun     (o4)
    );

    sample_sequencer #(.POINTS(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .sinc        (sinc),
        .start       (start1),
        .stop        (stop),
        .n_ciclos    (n_ciclos),
        .sample_ready(ready),
        .sample_valid(v1),
        .sample_index(i1),
        .sample_first(f1),
        .sample_last (l1),
        .busy        (b1),
        .done        (d1),
        .overrun     (o1)
    );

    // Free-running sinc source, period 10 cycles, 50% duty.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 10;
            gen_sinc = (ph < 5);
        end
    end

    // Handshake monitor: valid & ready at the negedge means an accept at the next posedge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            acc4        <= 0;
            done_cnt4   <= 0;
            idx_pack4   <= '0;
            first_mask4 <= '0;
            last_mask4  <= '0;
            acc1        <= 0;
            done_cnt1   <= 0;
            first_mask1 <= '0;
            last_mask1  <= '0;
            idx_or1     <= 1'b0;
        end else begin
            if (v4 && ready) begin
                if (acc4 < 16) idx_pack4[acc4*2 +: 2] <= i4;
                if (acc4 < 32) begin
                    first_mask4[acc4] <= f4;
                    last_mask4[acc4]  <= l4;
                end
                acc4      <= acc4 + 1;
                last_acc4 <= cyc;
            end
            if (d4) begin
                done_cnt4 <= done_cnt4 + 1;
                done_cyc4 <= cyc;
            end
            if (v1 && ready) begin
                if (acc1 < 32) begin
                    first_mask1[acc1] <= f1;
                    last_mask1[acc1]  <= l1;
                end
                idx_or1 <= idx_or1 | i1[0];
                acc1    <= acc1 + 1;
            end
            if (d1) done_cnt1 <= done_cnt1 + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_basic(input string p);
        ready    = 1'b1;
        n_ciclos = 32'd2;
        sinc_en  = 1'b1;
        mon_clr  = 1'b1;
        start4   = 1'b1;
        step();
        start4  = 1'b0;
        mon_clr = 1'b0;
        for (int k = 0; k < 300 && b4; k++) step();
        check_eq({p, "_ended"},     {31'b0, b4}, 32'd0);
        check_eq({p, "_accepts"},   acc4, 32'd8);
        check_eq({p, "_indices"},   {16'b0, idx_pack4[15:0]}, 32'h0000_E4E4);
        check_eq({p, "_first"},     first_mask4, 32'h11);
        check_eq({p, "_last"},      last_mask4, 32'h80);
        check_eq({p, "_done_cnt"},  done_cnt4, 32'd1);
        check_eq({p, "_done_dly"},  done_cyc4 - last_acc4, 32'd1);
        check_eq({p, "_overrun"},   {31'b0, o4}, 32'd0);
    endtask

    initial begin
        logic found, stable, ov9, ov10, anylast, anyv;
        int   nreq;

        reset = 1'b1; start4 = 1'b0; start1 = 1'b0; stop = 1'b0;
        ready = 1'b1; n_ciclos = '0;
        repeat (3) step();
        check_eq("reset_out4", {24'b0, v4, i4, f4, l4, b4, d4, o4}, 32'd0);
        check_eq("reset_out1", {25'b0, v1, i1, f1, l1, b1, d1, o1}, 32'd0);
        reset   = 1'b0;
        sinc_en = 1'b1;
        repeat (12) step();
        check_eq("idle_quiet", {30'b0, b4, v4}, 32'd0);

        run_basic("basic");

        // Backpressure in continuous mode
        ready = 1'b0; n_ciclos = '0; mon_clr = 1'b1; start4 = 1'b1;
        step();
        start4 = 1'b0; mon_clr = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (v4) found = 1'b1;
        end
        check_eq("bp_first_seen", {31'b0, found}, 32'd1);
        check_eq("bp_first_req", {29'b0, i4, f4}, {29'b0, 2'd0, 1'b1});
        stable = 1'b1; ov9 = 1'b1; ov10 = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (!(v4 && i4 == 2'd0)) stable = 1'b0;
            if (k == 9)  ov9  = o4;
            if (k == 10) ov10 = o4;
        end
        check_eq("bp_held_stable", {31'b0, stable}, 32'd1);
        check_eq("bp_ovr_before", {31'b0, ov9}, 32'd0);
        check_eq("bp_ovr_after", {31'b0, ov10}, 32'd1);
        ready = 1'b1;
        step();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (v4) found = 1'b1;
        end
        check_eq("bp_next_seen", {31'b0, found}, 32'd1);
        check_eq("bp_next_idx", {30'b0, i4}, 32'd3);
        check_eq("bp_next_first", {31'b0, f4}, 32'd0);
        check_eq("bp_overrun", {31'b0, o4}, 32'd1);
        check_eq("bp_accepts", acc4, 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("bp_stopped", {30'b0, b4, v4}, 32'd0);

        // Continuous run, 20 requests then stop with one pending
        ready = 1'b1; n_ciclos = '0; mon_clr = 1'b1; start4 = 1'b1;
        step();
        start4 = 1'b0; mon_clr = 1'b0;
        check_eq("cont_ovr_cleared", {31'b0, o4}, 32'd0);
        nreq = 0; anylast = 1'b0;
        for (int k = 0; k < 400 && nreq < 20; k++) begin
            step();
            if (v4) begin
                nreq++;
                anylast = anylast | l4;
            end
        end
        check_eq("cont_requests", nreq, 32'd20);
        check_eq("cont_pending", {31'b0, v4}, 32'd1);
        ready = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0; ready = 1'b1;
        check_eq("cont_last_never", {31'b0, anylast}, 32'd0);
        check_eq("cont_valid_drop", {31'b0, v4}, 32'd0);
        check_eq("cont_busy_fall", {31'b0, b4}, 32'd0);
        repeat (3) step();
        check_eq("cont_no_done", done_cnt4, 32'd0);

        // start and stop together
        start4 = 1'b1; stop = 1'b1;
        step();
        start4 = 1'b0; stop = 1'b0;
        check_eq("ss_idle", {31'b0, b4}, 32'd0);
        step();
        check_eq("ss_idle_later", {31'b0, b4}, 32'd0);

        // sinc already high at start
        sinc_man = 1'b1; sinc_en = 1'b0;
        repeat (3) step();
        n_ciclos = '0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        anyv = 1'b0;
        repeat (6) begin
            step();
            anyv = anyv | v4;
        end
        check_eq("hs_no_req", {31'b0, anyv}, 32'd0);
        check_eq("hs_busy", {31'b0, b4}, 32'd1);
        sinc_man = 1'b0;
        repeat (2) step();
        sinc_man = 1'b1;
        step();
        check_eq("hs_lat_edge1", {31'b0, v4}, 32'd0);
        step();
        check_eq("hs_lat_edge2", {29'b0, v4, i4}, {29'b0, 1'b1, 2'd0});
        stop = 1'b1;
        step();
        stop = 1'b0; sinc_man = 1'b0; sinc_en = 1'b1;

        // POINTS=1, three periods
        ready = 1'b1; n_ciclos = 32'd3; mon_clr = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0; mon_clr = 1'b0;
        for (int k = 0; k < 200 && b1; k++) step();
        check_eq("p1_ended", {31'b0, b1}, 32'd0);
        check_eq("p1_accepts", acc1, 32'd3);
        check_eq("p1_first", first_mask1, 32'h7);
        check_eq("p1_last", last_mask1, 32'h4);
        check_eq("p1_index", {31'b0, idx_or1}, 32'd0);
        check_eq("p1_done", done_cnt1, 32'd1);

        // Reset while draining the final request
        ready = 1'b1; n_ciclos = 32'd1; mon_clr = 1'b1; start4 = 1'b1;
        step();
        start4 = 1'b0; mon_clr = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (v4 && l4) found = 1'b1;
        end
        check_eq("rd_drain_seen", {31'b0, found}, 32'd1);
        reset = 1'b1;
        step();
        check_eq("rd_outputs", {24'b0, v4, i4, f4, l4, b4, d4, o4}, 32'd0);
        reset = 1'b0;
        step();
        run_basic("again");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sample_sequencer.md
# sample_sequencer

Consumes the periodic `sinc` strobe produced by the acquisition timer and turns each rising edge into an indexed sample request for the downstream capture/accumulation path. It runs a run/stop sequence of a programmable number of periods, each `POINTS` ticks long, and tags every request with its phase index and with first/last markers. Output uses a valid/ready handshake. A tick that arrives while the previous request is still pending is dropped and flagged.

## Interface
- `POINTS`, 8: ticks per period; legal range ≥1.
- `IDX_W`, `$clog2(POINTS)` (min 1): width of `sample_index`.
- `CNT_W`, 32: width of the period counter and `n_ciclos`.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `sinc`  in  1  timer output, same clock domain, about 50% duty.
- `start`  in  1  one-cycle pulse; arms a run from IDLE.
- `stop`  in  1  one-cycle pulse; aborts the run.
- `n_ciclos`  in  CNT_W  periods per run, sampled at `start`; 0 means continuous until `stop`.
- `sample_ready`  in  1  downstream accepts the request.
- `sample_valid`  out  1  request pending.
- `sample_index`  out  IDX_W  phase index 0..POINTS-1.
- `sample_first`  out  1  `sample_index == 0`.
- `sample_last`  out  1  last index of the final period; never set in continuous mode.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a run completes normally.
- `overrun`  out  1  sticky; set when a tick is dropped, cleared by `start` or `reset`.

## Operation
- Edge detect:
  - `sinc_d` is `sinc` registered.
  - `tick = sinc & ~sinc_d`.
  - Ticks are ignored outside RUN.
- States:
  - IDLE: `start` latches `n_ciclos`, clears `idx`, `per_cnt` and `overrun`, then goes to RUN.
  - RUN: every tick is handled as follows.
    - If the slot is free, meaning `!sample_valid | sample_ready`, load `sample_index = idx` and assert `sample_valid`.
    - Otherwise drop the tick and set `overrun`.
    - Either way, `idx` advances. At `POINTS-1` it wraps to 0 and `per_cnt` increments.
    - On the tick carrying index `POINTS-1` when `per_cnt == n_ciclos-1` (nonzero mode): if that request was issued, go to DRAIN; if it was dropped, go to DONE.
  - DRAIN: wait for the handshake (`sample_valid & sample_ready`), then go to DONE. Ticks are ignored.
  - DONE: assert `done` for one cycle, then go to IDLE.
- `stop` in RUN or DRAIN: next state IDLE, `sample_valid` drops, no `done`.
- `start` outside IDLE is ignored. `start` and `stop` in the same cycle: `stop` wins.
- Handshake:
  - Request data is held stable while `sample_valid & !sample_ready`.
  - A tick in the same cycle as an accepted handshake loads the new request, so there is no bubble.
- Widths:
  - `per_cnt` is CNT_W and saturates at all-ones in continuous mode; there is no wrap event.
  - For POINTS=1, `idx` stays 0 and every tick ends a period.
- `sample_first` and `sample_last` are registered together with `sample_index`.

## Timing
- Reset values: `sample_valid`, `sample_index`, `sample_first`, `sample_last`, `busy`, `done`, `overrun` all 0. `sinc_d` is 0. State is IDLE.
- Reset mid-run returns to IDLE on the next edge. A pending request is discarded.
- Latency: `sinc` is sampled high at edge t (low at t-1), so `sample_valid` is high after edge t+1.
- `busy` rises the cycle after `start` and falls the cycle after DONE. `done` and `busy` are both high in the DONE cycle.
- `overrun` is set the cycle after the dropped tick.
- A `sinc` that is already high at `start` produces no tick until its next rising edge.

## Structure
- Shared package `lockin_seq_pkg`:
  - state enum: IDLE, RUN, DRAIN, DONE;
  - function `idx_width(points)`.
- One sub-module, `rise_detect`, which registers the input and produces the one-cycle rising-edge pulse. The FSM, counters and output register stay in `sample_sequencer`.

## Test plan
- Basic run, POINTS=4, n_ciclos=2, `sample_ready` tied 1, tick every 10 cycles, then `start`:
  - 8 requests with indices 0,1,2,3,0,1,2,3;
  - `sample_first` on requests 1 and 5, `sample_last` on request 8 only;
  - `done` 1 cycle after the 8th accept;
  - `overrun`=0.
- Backpressure, `sample_ready` held 0 for 25 cycles at tick period 10:
  - first request held stable;
  - 2 ticks dropped, `overrun`=1;
  - next request index = 3 (phase preserved).
- Continuous mode, n_ciclos=0, 20 ticks then `stop`:
  - 20 requests, `sample_last` never set;
  - `busy` falls, no `done`;
  - a pending `sample_valid` drops on the next edge.
- Boundary cases:
  - `start`+`stop` in the same cycle: stays IDLE.
  - `start` with `sinc` already high: first request appears only after the next rising edge.
  - POINTS=1, n_ciclos=3: 3 requests, all index 0 with `sample_first` set, last flagged.
- Reset mid-DRAIN with `sample_valid`=1:
  - all outputs 0 next cycle;
  - a new `start` run then behaves as in the basic-run case.
